bus_arbiter: RTL

- Single-port memory arbiter between the two private L1 caches (instruction and data side each) and the shared RAM.
- Sits downstream of the coherency controller: honours its free-to-move and snoop-writeback indications when granting data-side requests.
- Grants one requester at a time, round-robin between cores, with data priority over instruction.
- Holds a grant across a cache-block burst so two-word block fills and writebacks are never interleaved.

---
 rtl/bus_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Single-port RAM arbiter that sits between two cores' private L1 caches
//   (an instruction side and a data side per core) and the shared RAM. It sits
//   downstream of the coherency controller. One requester holds the RAM at a
//   time, and the grant is kept across a block burst so that two-word fills
//   and writebacks are never interleaved.
//
//   Arbitration order:
//     1. snoop writeback from the coherency controller (data write)
//     2. data requests, round-robin between the cores
//     3. instruction requests, round-robin between the cores
//
// Ports
//   CLK, RST        clock (rising edge) and asynchronous active-high reset
//   iREN, iaddr     per-core instruction read request and address
//   dREN, dWEN      per-core data read / write request
//   daddr, dstore   per-core data address and write data
//   coh_free        coherency controller idle; new data reads may be granted
//   coh_wb          coherency controller is performing a snoop writeback
//   coh_wb_core     core performing that writeback
//   iwait, dwait    per-core stalls; low only in the owner's completing cycle
//   iload, dload    per-core read data, routed from ramload to the owner
//   ramREN, ramWEN  RAM read and write enables
//   ramaddr         RAM address
//   ramstore        RAM write data
//   ramload         RAM read data
//   ramstate        RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   bus_err         high for one cycle when an access completes with ERROR
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int WORD_W    = 32,
  parameter int BURST_MAX = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             iREN,
  input  logic [1:0][WORD_W-1:0] iaddr,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  input  logic                   coh_free,
  input  logic                   coh_wb,
  input  logic                   coh_wb_core,
  output logic [1:0]             iwait,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] iload,
  output logic [1:0][WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic                   bus_err
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // The grant kind (data or instruction) is carried by the state itself.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rr_data_q, rr_data_d;   // core that last received a data grant
  logic             rr_inst_q, rr_inst_d;   // core that last received an instruction grant

  logic       granted;
  logic       own_req;
  logic       done;
  logic       last_word;
  logic       release_grant;
  logic [1:0] d_elig;
  logic       arb_valid;
  logic       arb_data;
  logic       arb_core;

  // Status decode for the current grant.
  always_comb begin
    granted = (state_q != IDLE);
    own_req = 1'b0;
    if (state_q == GRANT_D) begin
      own_req = dREN[owner_q] | dWEN[owner_q];
    end else if (state_q == GRANT_I) begin
      own_req = iREN[owner_q];
    end
    done          = granted && ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));
    last_word     = done && (burst_cnt_q == CNT_W'(BURST_MAX - 1));
    // A dropped request (including "no request at all") frees the RAM at the
    // next edge, and so does a burst that has reached its limit.
    release_grant = granted && (!own_req || last_word);
  end

  // Candidate for the next grant. The result is only used while idle or on
  // release, which makes a snoop writeback wait for the current grant to end.
  always_comb begin
    d_elig    = dWEN | (dREN & {2{coh_free}});
    arb_valid = 1'b0;
    arb_data  = 1'b0;
    arb_core  = 1'b0;
    if (coh_wb && dWEN[coh_wb_core]) begin
      arb_valid = 1'b1;
      arb_data  = 1'b1;
      arb_core  = coh_wb_core;
    end else if (|d_elig) begin
      arb_valid = 1'b1;
      arb_data  = 1'b1;
      arb_core  = (&d_elig) ? ~rr_data_q : d_elig[1];
    end else if (|iREN) begin
      arb_valid = 1'b1;
      arb_data  = 1'b0;
      arb_core  = (&iREN) ? ~rr_inst_q : iREN[1];
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      burst_cnt_q <= '0;
      rr_data_q   <= 1'b0;
      rr_inst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rr_data_q   <= rr_data_d;
      rr_inst_q   <= rr_inst_d;
    end
  end

  // Next-state logic. Release and re-arbitration happen at the same edge, so
  // back-to-back grants need no idle cycle in between.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_data_d   = rr_data_q;
    rr_inst_d   = rr_inst_q;
    if (!granted || release_grant) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
      if (arb_valid) begin
        state_d = arb_data ? GRANT_D : GRANT_I;
        owner_d = arb_core;
        if (arb_data) begin
          rr_data_d = arb_core;
        end else begin
          rr_inst_d = arb_core;
        end
      end
    end else if (done) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  // Output logic. The outputs are derived from the registered grant, so an
  // asynchronous reset drops the RAM enables in the same cycle.
  always_comb begin
    iwait    = 2'b11;
    dwait    = 2'b11;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    bus_err  = 1'b0;
    case (state_q)
      GRANT_D: begin
        // A write takes precedence when the core asserts both enables.
        ramWEN         = dWEN[owner_q];
        ramREN         = dREN[owner_q] & ~dWEN[owner_q];
        ramaddr        = daddr[owner_q];
        if (dWEN[owner_q]) begin
          ramstore = dstore[owner_q];
        end
        dload[owner_q] = ramload;
        dwait[owner_q] = ~done;
        bus_err        = done && (ramstate == RAM_ERROR);
      end
      GRANT_I: begin
        ramREN         = iREN[owner_q];
        ramaddr        = iaddr[owner_q];
        iload[owner_q] = ramload;
        iwait[owner_q] = ~done;
        bus_err        = done && (ramstate == RAM_ERROR);
      end
      default: begin
      end
    endcase
  end

endmodule
